// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: register tag width,
// forward-select encodings and the memory-wait state machine states.
package pipe_pkg;

  localparam int REG_TAG_W = 4;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_ERR  = 2'd2
  } mem_state_e;

  // A stage source matches a producer tag only when that source is actually read.
  function automatic logic tag_hit(input logic                 valid,
                                   input logic [REG_TAG_W-1:0] src,
                                   input logic [REG_TAG_W-1:0] dest);
    return valid && (src == dest);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational operand-forward selection for the two EXE source tags.
// The MEM-stage result is newer than the WB value, so it wins when both match.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [REG_TAG_W-1:0] exe_src1,
  input  logic [REG_TAG_W-1:0] exe_src2,
  input  logic                 mem_wb_en,
  input  logic [REG_TAG_W-1:0] mem_dest,
  input  logic                 wb_wb_en,
  input  logic [REG_TAG_W-1:0] wb_dest,
  output logic [1:0]           fwd_sel1,
  output logic [1:0]           fwd_sel2
);

  logic [1:0][REG_TAG_W-1:0] src;
  logic [1:0][1:0]           sel;

  assign src = {exe_src2, exe_src1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    always_comb begin
      sel[gi] = FWD_REG;
      if (FWD_EN) begin
        if (tag_hit(mem_wb_en, src[gi], mem_dest)) begin
          sel[gi] = FWD_MEM;
        end else if (tag_hit(wb_wb_en, src[gi], wb_dest)) begin
          sel[gi] = FWD_WB;
        end
      end
    end
  end

  assign fwd_sel1 = sel[0];
  assign fwd_sel2 = sel[1];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: forwarding, stall/flush decisions, the
// memory-wait freeze state machine with timeout, and saturating activity counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter bit FWD_EN      = 1'b1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_TAG_W-1:0] id_src1,
  input  logic [REG_TAG_W-1:0] id_src2,
  input  logic                 id_src1_v,
  input  logic                 id_src2_v,
  input  logic [REG_TAG_W-1:0] exe_src1,
  input  logic [REG_TAG_W-1:0] exe_src2,
  input  logic                 exe_wb_en,
  input  logic [REG_TAG_W-1:0] exe_dest,
  input  logic                 exe_mem_r_en,
  input  logic                 exe_br_taken,
  input  logic                 mem_wb_en,
  input  logic [REG_TAG_W-1:0] mem_dest,
  input  logic                 mem_req,
  input  logic                 sram_ready,
  input  logic                 wb_wb_en,
  input  logic [REG_TAG_W-1:0] wb_dest,
  output logic [1:0]           fwd_sel1,
  output logic [1:0]           fwd_sel2,
  output logic                 stall,
  output logic                 flush,
  output logic                 freeze,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     freeze_cnt
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  mem_state_e              state_reg, state_next;
  logic [WAIT_W-1:0]       wait_cnt_reg, wait_cnt_next;
  logic                    mem_err_reg, err_set;
  logic [CNT_W-1:0]        stall_cnt_reg, freeze_cnt_reg;

  logic [1:0][REG_TAG_W-1:0] id_src;
  logic [1:0]                id_v;
  logic [1:0]                hit_exe, hit_mem;
  logic                      raw_hazard, freeze_int, flush_int;

  fwd_unit #(.FWD_EN(FWD_EN)) u_fwd (
    .exe_src1  (exe_src1),
    .exe_src2  (exe_src2),
    .mem_wb_en (mem_wb_en),
    .mem_dest  (mem_dest),
    .wb_wb_en  (wb_wb_en),
    .wb_dest   (wb_dest),
    .fwd_sel1  (fwd_sel1),
    .fwd_sel2  (fwd_sel2)
  );

  assign id_src = {id_src2, id_src1};
  assign id_v   = {id_src2_v, id_src1_v};

  for (genvar gi = 0; gi < 2; gi++) begin : g_hit
    assign hit_exe[gi] = tag_hit(id_v[gi], id_src[gi], exe_dest);
    assign hit_mem[gi] = tag_hit(id_v[gi], id_src[gi], mem_dest);
  end

  // With forwarding only a load in EXE cannot supply its value in time.
  if (FWD_EN) begin : g_fwd_hz
    assign raw_hazard = exe_mem_r_en && exe_wb_en && (|hit_exe);
  end else begin : g_nofwd_hz
    assign raw_hazard = (exe_wb_en && (|hit_exe)) || (mem_wb_en && (|hit_mem));
  end

  // The M_ERR cycle releases the freeze so the faulting access can retire.
  assign freeze_int = mem_req && !sram_ready && (state_reg != M_ERR);
  assign flush_int  = exe_br_taken && !freeze_int;

  assign freeze     = freeze_int;
  assign flush      = flush_int;
  assign stall      = raw_hazard && !flush_int && !freeze_int && !rst;
  assign mem_err    = mem_err_reg;
  assign stall_cnt  = stall_cnt_reg;
  assign freeze_cnt = freeze_cnt_reg;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    err_set       = 1'b0;
    case (state_reg)
      M_IDLE: begin
        if (mem_req && !sram_ready) begin
          state_next    = M_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      M_WAIT: begin
        if (!mem_req || sram_ready) begin
          state_next    = M_IDLE;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          state_next    = M_ERR;
          wait_cnt_next = '0;
          err_set       = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end
      M_ERR: begin
        state_next    = M_IDLE;
        wait_cnt_next = '0;
      end
      default: begin
        state_next    = M_IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= M_IDLE;
      wait_cnt_reg   <= '0;
      mem_err_reg    <= 1'b0;
      stall_cnt_reg  <= '0;
      freeze_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_reg || err_set;
      if (stall && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (freeze_int && (freeze_cnt_reg != '1)) begin
        freeze_cnt_reg <= freeze_cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (forwarding / no forwarding) driven
// in lockstep and compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, exe_src1, exe_src2, exe_dest, mem_dest, wb_dest;
  logic       id_src1_v, id_src2_v, exe_wb_en, exe_mem_r_en, exe_br_taken;
  logic       mem_wb_en, mem_req, sram_ready, wb_wb_en;

  logic [1:0]  fs1 [2];
  logic [1:0]  fs2 [2];
  logic        st_o [2];
  logic        fl_o [2];
  logic        fr_o [2];
  logic        er_o [2];
  logic [3:0]  a_scnt, a_fcnt;
  logic [15:0] b_scnt, b_fcnt;
  logic [31:0] cnt_s [2];
  logic [31:0] cnt_f [2];

  assign cnt_s[0] = 32'(a_scnt);
  assign cnt_f[0] = 32'(a_fcnt);
  assign cnt_s[1] = 32'(b_scnt);
  assign cnt_f[1] = 32'(b_fcnt);

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(8), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_v(id_src1_v), .id_src2_v(id_src2_v), .exe_src1(exe_src1),
    .exe_src2(exe_src2), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
    .exe_mem_r_en(exe_mem_r_en), .exe_br_taken(exe_br_taken),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_req(mem_req),
    .sram_ready(sram_ready), .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
    .fwd_sel1(fs1[0]), .fwd_sel2(fs2[0]), .stall(st_o[0]), .flush(fl_o[0]),
    .freeze(fr_o[0]), .mem_err(er_o[0]), .stall_cnt(a_scnt), .freeze_cnt(a_fcnt)
  );

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .MEM_TIMEOUT(64), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_v(id_src1_v), .id_src2_v(id_src2_v), .exe_src1(exe_src1),
    .exe_src2(exe_src2), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
    .exe_mem_r_en(exe_mem_r_en), .exe_br_taken(exe_br_taken),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_req(mem_req),
    .sram_ready(sram_ready), .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
    .fwd_sel1(fs1[1]), .fwd_sel2(fs2[1]), .stall(st_o[1]), .flush(fl_o[1]),
    .freeze(fr_o[1]), .mem_err(er_o[1]), .stall_cnt(b_scnt), .freeze_cnt(b_fcnt)
  );

  // Per-instance parameters and model state.
  int    fwd_p [2] = '{1, 0};
  int    tmo_p [2] = '{8, 64};
  int    cmax  [2] = '{15, 65535};
  string nm    [2] = '{"A", "B"};
  int    m_run [2];
  int    m_scnt [2];
  int    m_fcnt [2];
  bit    m_err [2];
  bit    m_errcyc [2];
  bit    ex_st [2];
  bit    ex_fr [2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit needs(input logic [3:0] x);
    return (id_src1_v && id_src1 == x) || (id_src2_v && id_src2 == x);
  endfunction

  function automatic int exp_fwd(input int i, input logic [3:0] src);
    if (fwd_p[i] == 0) return 0;
    if (mem_wb_en && mem_dest == src) return 1;
    if (wb_wb_en && wb_dest == src) return 2;
    return 0;
  endfunction

  // Compare all outputs of both instances against the model for the current inputs.
  task automatic eval(input string tag);
    #1;
    for (int i = 0; i < 2; i++) begin
      bit hz, fr, fl, st;
      if (fwd_p[i] != 0) hz = exe_mem_r_en && exe_wb_en && needs(exe_dest);
      else hz = (exe_wb_en && needs(exe_dest)) || (mem_wb_en && needs(mem_dest));
      fr = mem_req && !sram_ready && !m_errcyc[i];
      fl = exe_br_taken && !fr;
      st = hz && !fl && !fr && !rst;
      ex_st[i] = st;
      ex_fr[i] = fr;
      check($sformatf("%s.%s.fwd1", tag, nm[i]), 32'(fs1[i]), 32'(exp_fwd(i, exe_src1)));
      check($sformatf("%s.%s.fwd2", tag, nm[i]), 32'(fs2[i]), 32'(exp_fwd(i, exe_src2)));
      check($sformatf("%s.%s.stall", tag, nm[i]), 32'(st_o[i]), 32'(st));
      check($sformatf("%s.%s.flush", tag, nm[i]), 32'(fl_o[i]), 32'(fl));
      check($sformatf("%s.%s.freeze", tag, nm[i]), 32'(fr_o[i]), 32'(fr));
      check($sformatf("%s.%s.mem_err", tag, nm[i]), 32'(er_o[i]), 32'(m_err[i]));
      check($sformatf("%s.%s.stall_cnt", tag, nm[i]), cnt_s[i], 32'(m_scnt[i]));
      check($sformatf("%s.%s.freeze_cnt", tag, nm[i]), cnt_f[i], 32'(m_fcnt[i]));
    end
    $display("step %-10s rst=%0b req=%0b rdy=%0b br=%0b A:st=%0b fr=%0b err=%0b B:st=%0b fr=%0b",
             tag, rst, mem_req, sram_ready, exe_br_taken, st_o[0], fr_o[0], er_o[0], st_o[1], fr_o[1]);
  endtask

  // Advance the model by one clock edge, then move to the next drive point.
  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_run[i] = 0; m_scnt[i] = 0; m_fcnt[i] = 0; m_err[i] = 0; m_errcyc[i] = 0;
      end else begin
        if (ex_st[i] && m_scnt[i] < cmax[i]) m_scnt[i]++;
        if (ex_fr[i] && m_fcnt[i] < cmax[i]) m_fcnt[i]++;
        m_errcyc[i] = 0;
        m_run[i] = ex_fr[i] ? m_run[i] + 1 : 0;
        if (m_run[i] == tmo_p[i]) begin
          m_err[i] = 1; m_errcyc[i] = 1; m_run[i] = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    eval(tag);
    tick();
  endtask

  task automatic idle_inputs();
    rst = 0; id_src1 = 0; id_src2 = 0; id_src1_v = 0; id_src2_v = 0;
    exe_src1 = 0; exe_src2 = 0; exe_wb_en = 0; exe_dest = 0; exe_mem_r_en = 0;
    exe_br_taken = 0; mem_wb_en = 0; mem_dest = 0; mem_req = 0; sram_ready = 0;
    wb_wb_en = 0; wb_dest = 0;
  endtask

  task automatic load_use();
    exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 5; id_src2 = 5; id_src2_v = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step("reset");
    rst = 0;
  endtask

  function automatic logic [3:0] rnd_tag();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_scnt[i] = 0; m_fcnt[i] = 0; m_err[i] = 0; m_errcyc[i] = 0;
    end

    // Reset state with idle inputs.
    eval("idle");
    check("idle.A.stall_zero", 32'(st_o[0]), 0);
    check("idle.A.freeze_zero", 32'(fr_o[0]), 0);
    tick();

    // Forwarding priority and the forwarding-disabled instance.
    exe_src1 = 3; mem_wb_en = 1; mem_dest = 3; wb_wb_en = 1; wb_dest = 3;
    eval("fwd_mem");
    check("fwd_mem.A.sel1", 32'(fs1[0]), 1);
    check("fwd_mem.B.sel1", 32'(fs1[1]), 0);
    tick();
    mem_wb_en = 0;
    eval("fwd_wb");
    check("fwd_wb.A.sel1", 32'(fs1[0]), 2);
    tick();
    exe_src2 = 15; wb_dest = 15; mem_wb_en = 1; mem_dest = 0;
    step("fwd_r15");

    // Load-use stall, then the same without a load.
    idle_inputs();
    load_use();
    eval("load_use");
    check("load_use.A.stall", 32'(st_o[0]), 1);
    tick();
    idle_inputs();
    eval("after_lu");
    check("after_lu.A.stall", 32'(st_o[0]), 0);
    check("after_lu.A.stall_cnt", cnt_s[0], 1);
    tick();
    load_use();
    exe_mem_r_en = 0;
    eval("no_load");
    check("no_load.A.stall", 32'(st_o[0]), 0);
    check("no_load.B.stall", 32'(st_o[1]), 1);
    tick();

    // A taken branch overrides the load-use stall.
    load_use();
    exe_br_taken = 1;
    eval("br_stall");
    check("br_stall.A.flush", 32'(fl_o[0]), 1);
    check("br_stall.A.stall", 32'(st_o[0]), 0);
    tick();

    // SRAM wait of four cycles.
    do_reset();
    idle_inputs();
    mem_req = 1;
    for (int k = 0; k < 4; k++) begin
      eval("sram_wait");
      check("sram_wait.A.freeze", 32'(fr_o[0]), 1);
      tick();
    end
    sram_ready = 1;
    eval("sram_rdy");
    check("sram_rdy.A.freeze", 32'(fr_o[0]), 0);
    tick();
    idle_inputs();
    eval("sram_done");
    check("sram_done.A.freeze_cnt", cnt_f[0], 4);
    check("sram_done.A.mem_err", 32'(er_o[0]), 0);
    tick();

    // Timeout on instance A.
    mem_req = 1;
    for (int k = 0; k < 8; k++) begin
      eval("tmo_wait");
      check("tmo_wait.A.freeze", 32'(fr_o[0]), 1);
      tick();
    end
    eval("tmo_err");
    check("tmo_err.A.freeze", 32'(fr_o[0]), 0);
    check("tmo_err.A.mem_err", 32'(er_o[0]), 1);
    tick();
    idle_inputs();
    step("tmo_after");
    eval("tmo_sticky");
    check("tmo_sticky.A.mem_err", 32'(er_o[0]), 1);
    tick();
    do_reset();
    eval("tmo_clear");
    check("tmo_clear.A.mem_err", 32'(er_o[0]), 0);
    tick();

    // Reset in the middle of a wait.
    mem_req = 1;
    repeat (3) step("mid_wait");
    rst = 1;
    step("mid_rst");
    idle_inputs();
    eval("mid_after");
    check("mid_after.A.freeze_cnt", cnt_f[0], 0);
    check("mid_after.A.freeze", 32'(fr_o[0]), 0);
    tick();

    // Stall counter saturation on the 4-bit instance.
    load_use();
    repeat (20) step("sat");
    idle_inputs();
    eval("sat_end");
    check("sat_end.A.stall_cnt", cnt_s[0], 15);
    tick();

    // Randomized traffic, including slow-SRAM stretches that reach the timeout.
    for (int n = 0; n < 600; n++) begin
      bit slow;
      slow = (n / 100) % 2 == 1;
      rst = ($urandom_range(0, 149) == 0);
      id_src1 = rnd_tag(); id_src2 = rnd_tag();
      id_src1_v = 1'($urandom); id_src2_v = 1'($urandom);
      exe_src1 = rnd_tag(); exe_src2 = rnd_tag(); exe_dest = rnd_tag();
      exe_wb_en = 1'($urandom); exe_mem_r_en = 1'($urandom);
      exe_br_taken = ($urandom_range(0, 5) == 0);
      mem_wb_en = 1'($urandom); mem_dest = rnd_tag();
      wb_wb_en = 1'($urandom); wb_dest = rnd_tag();
      mem_req = ($urandom_range(0, 9) != 0);
      sram_ready = slow ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
